// File: rtl/led_pattern_gen_if.sv
// Pin-level bundle between the board switches, the LED pattern generator and the LED pins.
// The master drives mode/dir/pause; the slave (the generator) drives the LEDs, pulses and debug state.
interface led_pattern_gen_if #(
    parameter int N_LED = 8
);
    localparam int PW = (N_LED > 1) ? $clog2(N_LED) : 1;

    logic [1:0]       mode_i;
    logic             dir_i;
    logic             pause_i;
    logic [N_LED-1:0] led_o;
    logic             step_tick_o;
    logic             wrap_o;
    logic [PW-1:0]    dbg_pos_o;
    logic             dbg_phase_o;

    modport master (
        output mode_i, dir_i, pause_i,
        input  led_o, step_tick_o, wrap_o, dbg_pos_o, dbg_phase_o
    );

    modport slave (
        input  mode_i, dir_i, pause_i,
        output led_o, step_tick_o, wrap_o, dbg_pos_o, dbg_phase_o
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: divides clk to a step enable and walks N_LED LEDs
// through fill, walk, bounce or fill-drain, with output mirroring and pause.
module led_pattern_gen #(
    parameter int N_LED   = 8,
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 1
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_gen_if.slave  bus
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [DW-1:0] DIV_LAST        = DW'(DIV - 1);
    localparam logic [PW-1:0] POS_LAST        = PW'(N_LED - 1);
    localparam logic [PW-1:0] POS_BEFORE_LAST = PW'(N_LED - 2);
    localparam logic [PW-1:0] POS_ONE         = PW'(1);

    typedef enum logic [1:0] {M_FILL, M_WALK, M_BOUNCE, M_FILL_DRAIN} mode_e;
    typedef enum logic {PH_UP, PH_DOWN} phase_e;

    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    phase_e           phase_q, phase_d;
    mode_e            mode_q, mode_in;
    logic             started_q;
    logic [N_LED-1:0] led_q, led_d, raw;
    logic             step_tick_q, wrap_q;
    logic             tick, restart, wrap_d;

    assign mode_in = mode_e'(bus.mode_i);
    assign tick    = !bus.pause_i && (div_cnt_q == DIV_LAST);
    // The first tick and any mode change both restart the pattern at pos 0 without a wrap.
    assign restart = !started_q || (mode_in != mode_q);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!bus.pause_i) div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    always_comb begin
        pos_d   = '0;
        phase_d = PH_UP;
        if (!restart) begin
            case (mode_q)
                M_FILL, M_WALK: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
                M_BOUNCE: begin
                    if (phase_q == PH_UP) begin
                        if (pos_q != POS_LAST) begin
                            pos_d = pos_q + POS_ONE;
                        end else if (N_LED > 2) begin
                            pos_d   = POS_BEFORE_LAST;
                            phase_d = PH_DOWN;
                        end
                    end else if (pos_q > POS_ONE) begin
                        pos_d   = pos_q - POS_ONE;
                        phase_d = PH_DOWN;
                    end
                end
                default: begin
                    // Fill-drain: pos sweeps 0..N-1 in each phase, phase flips at the top.
                    if (pos_q == POS_LAST) begin
                        phase_d = (phase_q == PH_UP) ? PH_DOWN : PH_UP;
                    end else begin
                        pos_d   = pos_q + POS_ONE;
                        phase_d = phase_q;
                    end
                end
            endcase
        end
    end

    always_comb begin
        raw   = '0;
        led_d = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (mode_in)
                M_FILL:         raw[i] = (i <= int'(pos_d));
                M_WALK, M_BOUNCE: raw[i] = (i == int'(pos_d));
                default:        raw[i] = (phase_d == PH_UP) ? (i <= int'(pos_d)) : (i > int'(pos_d));
            endcase
        end
        for (int i = 0; i < N_LED; i++) begin
            led_d[i] = bus.dir_i ? raw[N_LED-1-i] : raw[i];
        end
    end

    assign wrap_d = !restart && (pos_d == '0) && (phase_d == PH_UP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            pos_q       <= '0;
            phase_q     <= PH_UP;
            started_q   <= 1'b0;
            mode_q      <= M_FILL;
            led_q       <= '0;
            step_tick_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            step_tick_q <= tick;
            wrap_q      <= tick && wrap_d;
            if (tick) begin
                started_q <= 1'b1;
                mode_q    <= mode_in;
                pos_q     <= pos_d;
                phase_q   <= phase_d;
                led_q     <= led_d;
            end
        end
    end

    assign bus.led_o       = led_q;
    assign bus.step_tick_o = step_tick_q;
    assign bus.wrap_o      = wrap_q;
    assign bus.dbg_pos_o   = pos_q;
    assign bus.dbg_phase_o = (phase_q == PH_DOWN);
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LED=4, DIV=4: tick-by-tick vector table
// plus hand-written pause and asynchronous-reset sequences.
module tb_led_pattern_gen;
  localparam int N = 4;

  typedef struct {
    logic [1:0]   mode;
    logic         dir;
    logic [N-1:0] led;
    logic         wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  // clock/reset block
  always #5 clk = ~clk;

  led_pattern_gen_if #(.N_LED(N)) bus ();

  led_pattern_gen #(.N_LED(N), .CLK_HZ(4), .STEP_HZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic d, input logic [N-1:0] l, input logic w);
    vec_t v;
    v.mode = m; v.dir = d; v.led = l; v.wrap = w;
    vecs.push_back(v);
  endtask

  // driver: wait (bounded) for the next step_tick, counting cycles since the call
  task automatic wait_tick(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (bus.step_tick_o) seen = 1'b1;
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [N-1:0] held;

    rst = 1'b1;
    bus.mode_i = 2'd0; bus.dir_i = 1'b0; bus.pause_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(bus.led_o), 32'h0);
    check("reset_tick", 32'(bus.step_tick_o), 32'h0);
    check("reset_wrap", 32'(bus.wrap_o), 32'h0);
    rst = 1'b0;

    // FILL from reset
    add(0, 0, 4'b0001, 0); add(0, 0, 4'b0011, 0); add(0, 0, 4'b0111, 0);
    add(0, 0, 4'b1111, 0); add(0, 0, 4'b0001, 1);
    // BOUNCE
    add(2, 0, 4'b0001, 0); add(2, 0, 4'b0010, 0); add(2, 0, 4'b0100, 0);
    add(2, 0, 4'b1000, 0); add(2, 0, 4'b0100, 0); add(2, 0, 4'b0010, 0);
    add(2, 0, 4'b0001, 1);
    // FILL_DRAIN
    add(3, 0, 4'b0001, 0); add(3, 0, 4'b0011, 0); add(3, 0, 4'b0111, 0);
    add(3, 0, 4'b1111, 0); add(3, 0, 4'b1110, 0); add(3, 0, 4'b1100, 0);
    add(3, 0, 4'b1000, 0); add(3, 0, 4'b0000, 0); add(3, 0, 4'b0001, 1);
    // WALK mirrored
    add(1, 1, 4'b1000, 0); add(1, 1, 4'b0100, 0); add(1, 1, 4'b0010, 0);
    add(1, 1, 4'b0001, 0); add(1, 1, 4'b1000, 1);
    // FILL, then switch to WALK on the tick that would wrap
    add(0, 0, 4'b0001, 0); add(0, 0, 4'b0011, 0); add(0, 0, 4'b0111, 0);
    add(0, 0, 4'b1111, 0); add(1, 0, 4'b0001, 0); add(1, 0, 4'b0010, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      bus.mode_i = vecs[k].mode;
      bus.dir_i  = vecs[k].dir;
      wait_tick(cyc, seen);
      if (!seen) begin
        check($sformatf("vec%0d_tick_timeout", k), 32'(seen), 32'h1);
      end else begin
        check($sformatf("vec%0d_spacing", k), 32'(cyc), 32'd4);
        check($sformatf("vec%0d_led", k), 32'(bus.led_o), 32'(vecs[k].led));
        check($sformatf("vec%0d_wrap", k), 32'(bus.wrap_o), 32'(vecs[k].wrap));
      end
    end

    // pause two cycles into a step: the remaining two cycles run after release
    repeat (2) @(negedge clk);
    bus.pause_i = 1'b1;
    held = bus.led_o;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("pause_tick", 32'(bus.step_tick_o), 32'h0);
      check("pause_led", 32'(bus.led_o), 32'(held));
    end
    bus.pause_i = 1'b0;
    wait_tick(cyc, seen);
    check("pause_resume_tick_seen", 32'(seen), 32'h1);
    check("pause_resume_spacing", 32'(cyc), 32'd2);
    check("pause_resume_led", 32'(bus.led_o), 32'b0100);

    // asynchronous reset landing while step_tick is high
    wait_tick(cyc, seen);
    check("pre_reset_tick_seen", 32'(seen), 32'h1);
    check("pre_reset_led", 32'(bus.led_o), 32'b1000);
    #2 rst = 1'b1;
    #1;
    check("async_reset_led", 32'(bus.led_o), 32'h0);
    check("async_reset_tick", 32'(bus.step_tick_o), 32'h0);
    repeat (2) @(negedge clk);
    bus.mode_i = 2'd0;
    rst = 1'b0;
    wait_tick(cyc, seen);
    check("post_reset_tick_seen", 32'(seen), 32'h1);
    check("post_reset_spacing", 32'(cyc), 32'd4);
    check("post_reset_led", 32'(bus.led_o), 32'b0001);
    check("post_reset_wrap", 32'(bus.wrap_o), 32'h0);
    wait_tick(cyc, seen);
    check("post_reset_led2", 32'(bus.led_o), 32'b0011);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
